// File: rtl/score_keeper_pkg.sv
// ============================================================================
// score_keeper_pkg : shared state encoding and widths for the score path
// Rev 1.0
// ============================================================================
`default_nettype none

package score_keeper_pkg;

  localparam int SCORE_W = 7;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_updown_counter.sv
// ============================================================================
// bcd_updown_counter : two-digit BCD up/down counter, clamped to [0, LIMIT]
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_updown_counter
  import score_keeper_pkg::*;
#(
  parameter int LIMIT = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] ones_o
);

  localparam logic [DIGIT_W-1:0] C_LIM_TENS = DIGIT_W'(LIMIT / 10);
  localparam logic [DIGIT_W-1:0] C_LIM_ONES = DIGIT_W'(LIMIT % 10);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               w_at_max;
  logic               w_at_zero;

  assign w_at_max  = (tens_q == C_LIM_TENS) && (ones_q == C_LIM_ONES);
  assign w_at_zero = (tens_q == '0) && (ones_q == '0);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr_i) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc_i && !dec_i && !w_at_max) begin
      if (ones_q == DIGIT_W'(9)) begin
        ones_d = '0;
        tens_d = tens_q + 1'b1;
      end else begin
        ones_d = ones_q + 1'b1;
      end
    end else if (dec_i && !inc_i && !w_at_zero) begin
      // ones digit borrows from tens when it wraps below zero
      if (ones_q == '0) begin
        ones_d = DIGIT_W'(9);
        tens_d = tens_q - 1'b1;
      end else begin
        ones_d = ones_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// score_keeper : round FSM, saturating score, countdown timer and best score
// Rev 1.0
// ============================================================================
`default_nettype none

module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int ROUND_SECS = 30,
  parameter int MAX_SCORE  = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  input  logic               tick_1s,
  output logic [SCORE_W-1:0] score,
  output logic [DIGIT_W-1:0] score_tens,
  output logic [DIGIT_W-1:0] score_ones,
  output logic [SCORE_W-1:0] best,
  output logic [SCORE_W-1:0] time_left,
  output logic               playing,
  output logic               game_over
);

  localparam logic [SCORE_W-1:0] C_MAX_SCORE  = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] C_ROUND_SECS = SCORE_W'(ROUND_SECS);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] time_q,  time_d;
  logic [SCORE_W-1:0] best_q,  best_d;
  logic               playing_q;
  logic               game_over_q;
  logic               w_clr;
  logic               w_inc;
  logic               w_dec;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    time_d  = time_q;
    best_d  = best_q;
    w_clr   = 1'b0;
    w_inc   = 1'b0;
    w_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PLAY;
          w_clr   = 1'b1;
          score_d = '0;
          time_d  = C_ROUND_SECS;
        end
      end
      PLAY: begin
        // the same gated strobes drive binary and BCD so they never diverge
        w_inc = hit && !miss && (score_q != C_MAX_SCORE);
        w_dec = miss && !hit && (score_q != '0);
        if (w_inc) begin
          score_d = score_q + 1'b1;
        end else if (w_dec) begin
          score_d = score_q - 1'b1;
        end
        if (tick_1s && (time_q != '0)) begin
          time_d = time_q - 1'b1;
          if (time_q == SCORE_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (score_q > best_q) begin
          best_d = score_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      score_q     <= '0;
      time_q      <= '0;
      best_q      <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      time_q      <= time_d;
      best_q      <= best_d;
      playing_q   <= (state_d == PLAY);
      game_over_q <= (state_q == DONE);
    end
  end

  bcd_updown_counter #(
    .LIMIT (MAX_SCORE)
  ) u_digits (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_clr),
    .inc_i  (w_inc),
    .dec_i  (w_dec),
    .tens_o (score_tens),
    .ones_o (score_ones)
  );

  assign score     = score_q;
  assign best      = best_q;
  assign time_left = time_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// tb_score_keeper : directed self-checking bench for score_keeper
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       tick = 1'b0;
  logic       tick3 = 1'b0;

  logic [6:0] score, best, time_left;
  logic [3:0] tens, ones;
  logic       playing, game_over;

  logic [6:0] score3, best3, time_left3;
  logic [3:0] tens3, ones3;
  logic       playing3, game_over3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  score_keeper #(.ROUND_SECS(15), .MAX_SCORE(99)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .tick_1s    (tick),
    .score      (score),
    .score_tens (tens),
    .score_ones (ones),
    .best       (best),
    .time_left  (time_left),
    .playing    (playing),
    .game_over  (game_over)
  );

  score_keeper #(.ROUND_SECS(3), .MAX_SCORE(99)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .tick_1s    (tick3),
    .score      (score3),
    .score_tens (tens3),
    .score_ones (ones3),
    .best       (best3),
    .time_left  (time_left3),
    .playing    (playing3),
    .game_over  (game_over3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock: inputs set before the call are sampled on this edge, then cleared
  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0; tick = 1'b0; tick3 = 1'b0;
  endtask

  task automatic run_round(input int n_hits, input logic hit_last,
                           input int exp_score, input int exp_best);
    start = 1'b1; step();
    repeat (n_hits) begin hit = 1'b1; step(); end
    repeat (14) begin tick = 1'b1; step(); end
    tick = 1'b1; hit = hit_last; step();
    chk("rnd_end_playing", playing, 0);
    step();
    chk("rnd_game_over", game_over, 1);
    chk("rnd_score", score, exp_score);
    chk("rnd_best", best, exp_best);
  endtask

  initial begin
    #1;
    rst = 1'b1; step();
    rst = 1'b1; step();
    chk("rst_score", score, 0);
    chk("rst_tens", tens, 0);
    chk("rst_ones", ones, 0);
    chk("rst_best", best, 0);
    chk("rst_time", time_left, 0);
    chk("rst_playing", playing, 0);
    chk("rst_game_over", game_over, 0);

    hit = 1'b1; step();
    chk("idle_hit_ignored", score, 0);

    start = 1'b1; step();
    chk("start_playing", playing, 1);
    chk("start_score", score, 0);
    chk("start_time", time_left, 15);

    repeat (12) begin hit = 1'b1; step(); end
    repeat (3) begin miss = 1'b1; step(); end
    chk("s9_score", score, 9);
    chk("s9_tens", tens, 0);
    chk("s9_ones", ones, 9);
    hit = 1'b1; step();
    chk("s10_score", score, 10);
    chk("s10_tens", tens, 1);
    chk("s10_ones", ones, 0);

    tick = 1'b1; step();
    chk("tick_time", time_left, 14);
    start = 1'b1; step();
    chk("start_in_play_time", time_left, 14);
    chk("start_in_play_score", score, 10);

    repeat (5) begin miss = 1'b1; step(); end
    chk("s5_score", score, 5);
    chk("s5_ones", ones, 5);
    hit = 1'b1; miss = 1'b1; step();
    chk("hit_miss_score", score, 5);
    chk("hit_miss_ones", ones, 5);

    repeat (15) begin hit = 1'b1; step(); end
    chk("s20_score", score, 20);
    chk("s20_tens", tens, 2);
    chk("s20_ones", ones, 0);

    repeat (13) begin tick = 1'b1; step(); end
    chk("t1_time", time_left, 1);
    tick = 1'b1; step();
    chk("end_playing", playing, 0);
    chk("end_time", time_left, 0);
    chk("end_go_early", game_over, 0);
    hit = 1'b1; step();
    chk("done_go", game_over, 1);
    chk("done_best", best, 20);
    chk("done_hit_ignored", score, 20);
    step();
    chk("go_one_cycle", game_over, 0);
    hit = 1'b1; step();
    chk("idle_holds_score", score, 20);

    run_round(15, 1'b0, 15, 20);
    run_round(20, 1'b0, 20, 20);
    run_round(20, 1'b1, 21, 21);
    chk("r4_tens", tens, 2);
    chk("r4_ones", ones, 1);

    rst = 1'b1; step();
    start = 1'b1; step();
    repeat (105) begin hit = 1'b1; step(); end
    chk("sat_score", score, 99);
    chk("sat_tens", tens, 9);
    chk("sat_ones", ones, 9);
    miss = 1'b1; step();
    chk("sat_dec_score", score, 98);
    chk("sat_dec_ones", ones, 8);

    rst = 1'b1; step();
    start = 1'b1; step();
    miss = 1'b1; step();
    chk("floor_score", score, 0);
    chk("floor_ones", ones, 0);

    repeat (7) begin hit = 1'b1; step(); end
    repeat (3) begin tick = 1'b1; step(); end
    chk("mid_score", score, 7);
    chk("mid_time", time_left, 12);
    rst = 1'b1; step();
    chk("midrst_score", score, 0);
    chk("midrst_ones", ones, 0);
    chk("midrst_time", time_left, 0);
    chk("midrst_playing", playing, 0);
    chk("midrst_go", game_over, 0);
    step();
    chk("midrst_go_next", game_over, 0);
    chk("midrst_idle", playing, 0);

    rst = 1'b1; step();
    start = 1'b1; step();
    repeat (4) begin hit = 1'b1; step(); end
    chk("r3_time3", time_left3, 3);
    tick3 = 1'b1; step();
    chk("r3_time2", time_left3, 2);
    tick3 = 1'b1; step();
    chk("r3_time1", time_left3, 1);
    tick3 = 1'b1; step();
    chk("r3_time0", time_left3, 0);
    chk("r3_playing", playing3, 0);
    chk("r3_go_early", game_over3, 0);
    step();
    chk("r3_go", game_over3, 1);
    chk("r3_best", best3, 4);
    step();
    chk("r3_go_once", game_over3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
